// File: rtl/wb_arbiter_2m_pkg.sv
// wb_arb_pkg: shared state type, bus widths and cycle-type codes for the two-master arbiter
package wb_arb_pkg;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} arb_state_t;
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;
endpackage

// File: rtl/wb_arbiter_2m_if.sv
// wshb_if: Wishbone bus bundle with registered-feedback cycle tags
interface wshb_if;
  import wb_arb_pkg::*;
  logic [AW-1:0] adr;
  logic [DW-1:0] dat_ms;
  logic [DW-1:0] dat_sm;
  logic [SW-1:0] sel;
  logic          stb;
  logic          we;
  logic          cyc;
  logic [2:0]    cti;
  logic [1:0]    bte;
  logic          ack;
  modport master (output adr, dat_ms, sel, stb, we, cyc, cti, bte, input dat_sm, ack);
  modport slave  (input adr, dat_ms, sel, stb, we, cyc, cti, bte, output dat_sm, ack);
endinterface

// File: rtl/wb_arbiter_2m_mux.sv
// wb_arb_mux: grant-driven 2:1 master-to-slave multiplexer with ack steering
module wb_arb_mux
  import wb_arb_pkg::*;
(
  input  logic [1:0] i_gnt,
  wshb_if.slave      wb_m0,
  wshb_if.slave      wb_m1,
  wshb_if.master     wb_s
);
  // Put the granted master on the slave port; with no grant everything reads as zero
  always_comb begin
    wb_s.adr    = i_gnt[0] ? wb_m0.adr    : i_gnt[1] ? wb_m1.adr    : '0;
    wb_s.dat_ms = i_gnt[0] ? wb_m0.dat_ms : i_gnt[1] ? wb_m1.dat_ms : '0;
    wb_s.sel    = i_gnt[0] ? wb_m0.sel    : i_gnt[1] ? wb_m1.sel    : '0;
    wb_s.we     = i_gnt[0] ? wb_m0.we     : i_gnt[1] ? wb_m1.we     : 1'b0;
    wb_s.cti    = i_gnt[0] ? wb_m0.cti    : i_gnt[1] ? wb_m1.cti    : '0;
    wb_s.bte    = i_gnt[0] ? wb_m0.bte    : i_gnt[1] ? wb_m1.bte    : '0;
    wb_s.cyc    = i_gnt[0] ? wb_m0.cyc    : i_gnt[1] ? wb_m1.cyc    : 1'b0;
    wb_s.stb    = i_gnt[0] ? wb_m0.stb    : i_gnt[1] ? wb_m1.stb    : 1'b0;
  end
  // Only the owner sees ack; read data fans out to both since ack qualifies it
  always_comb begin
    wb_m0.ack    = i_gnt[0] & wb_s.ack;
    wb_m1.ack    = i_gnt[1] & wb_s.ack;
    wb_m0.dat_sm = wb_s.dat_sm;
    wb_m1.dat_sm = wb_s.dat_sm;
  end
endmodule

// File: rtl/wb_arbiter_2m.sv
// wb_arbiter_2m: round-robin two-master Wishbone arbiter, grant held for a whole cyc period
module wb_arbiter_2m
  import wb_arb_pkg::*;
#(
  parameter int NB_MASTERS = 2,
  parameter bit FIRST_PRIO = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  wshb_if.slave      wb_m0,
  wshb_if.slave      wb_m1,
  wshb_if.master     wb_s,
  output logic [1:0] gnt
);
  arb_state_t r_state;
  arb_state_t w_next;
  logic       r_last;
  if (NB_MASTERS != 2) begin : g_bad_nb
    $error("wb_arbiter_2m supports exactly two masters");
  end
  // Grant register and last-served memory; reset abandons any cycle in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_last  <= ~FIRST_PRIO;
    end else begin
      r_state <= w_next;
      if (r_state == GNT0 && !wb_m0.cyc) r_last <= 1'b0;
      else if (r_state == GNT1 && !wb_m1.cyc) r_last <= 1'b1;
    end
  end
  // Hold the owner while its cyc stays up, hand over directly, tie-break away from last served
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = (wb_m0.cyc && wb_m1.cyc) ? (r_last ? GNT0 : GNT1) :
                        wb_m0.cyc ? GNT0 : wb_m1.cyc ? GNT1 : IDLE;
      GNT0:    w_next = wb_m0.cyc ? GNT0 : wb_m1.cyc ? GNT1 : IDLE;
      GNT1:    w_next = wb_m1.cyc ? GNT1 : wb_m0.cyc ? GNT0 : IDLE;
      default: w_next = IDLE;
    endcase
  end
  // One-hot grant decoded straight from the state register
  always_comb begin
    gnt = {r_state == GNT1, r_state == GNT0};
  end
  wb_arb_mux u_mux (
    .i_gnt (gnt),
    .wb_m0 (wb_m0),
    .wb_m1 (wb_m1),
    .wb_s  (wb_s)
  );
endmodule
